// File: rtl/ro_puf_seq_ctrl_pkg.sv
// RO PUF sequencer: shared state encoding and constants.
// Default widths match the PUF mux select and edge counters.
package ro_puf_seq_ctrl_pkg;

  localparam int DEF_SEL_W    = 8;
  localparam int DEF_CNT_W    = 16;
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_COUNT,
    ST_DRAIN,
    ST_COMPARE,
    ST_DONE
  } state_t;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ro_puf_seq_ctrl_if.sv
// RO PUF sequencer request interface.
// Master issues start/seed; slave returns busy/done/response.
interface ro_puf_seq_ctrl_if
  import ro_puf_seq_ctrl_pkg::*;
#(
  parameter int SEL_W     = DEF_SEL_W,
  parameter int RESP_BITS = 8
) ();

  logic                 start;
  logic [SEL_W-1:0]     chall_seed;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] response;
  logic                 tie;

  modport master (
    output start,
    output chall_seed,
    input  busy,
    input  done,
    input  response,
    input  tie
  );

  modport slave (
    input  start,
    input  chall_seed,
    output busy,
    output done,
    output response,
    output tie
  );

endinterface

// File: rtl/ro_puf_seq_ctrl_phase_timer.sv
// Loadable phase down-counter for the RO PUF sequencer.
// expire is high during the last cycle of a loaded phase.
module ro_puf_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/ro_puf_seq_ctrl.sv
// RO PUF sequencer: per-bit clear/settle/count/drain/compare.
// Sole owner of roen, counter clear/enable and challenge selects.
module ro_puf_seq_ctrl
  import ro_puf_seq_ctrl_pkg::*;
#(
  parameter int SEL_W     = DEF_SEL_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RESP_BITS = 8,
  parameter int SETTLE    = 16,
  parameter int WINDOW    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  ro_puf_seq_ctrl_if.slave bus,
  input  logic [CNT_W-1:0] count0,
  input  logic [CNT_W-1:0] count1,
  output logic             roen,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic [SEL_W-1:0] chall0,
  output logic [SEL_W-1:0] chall1
);

  localparam int TMAX = max3(SETTLE, WINDOW, DRAIN_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(RESP_BITS - 1);

  state_t               state;
  state_t               state_nx;
  logic                 tmr_load;
  logic [TW-1:0]        tmr_val;
  logic                 tmr_exp;
  logic [SEL_W-1:0]     idx;
  logic [SEL_W-1:0]     chall_q;
  logic [RESP_BITS-1:0] resp_q;
  logic                 tie_q;
  logic                 busy_c;
  logic                 done_c;
  logic                 last;

  assign last = (idx == LAST);

  ro_puf_phase_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expire  (tmr_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Timer is loaded on the edge that enters each timed phase.
  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) state_nx = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_nx = ST_SETTLE;
        tmr_load = 1'b1;
        tmr_val  = TW'(SETTLE);
      end
      ST_SETTLE: begin
        if (tmr_exp) begin
          state_nx = ST_COUNT;
          tmr_load = 1'b1;
          tmr_val  = TW'(WINDOW);
        end
      end
      ST_COUNT: begin
        if (tmr_exp) begin
          state_nx = ST_DRAIN;
          tmr_load = 1'b1;
          tmr_val  = TW'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (tmr_exp) state_nx = ST_COMPARE;
      end
      ST_COMPARE: begin
        state_nx = last ? ST_DONE : ST_CLEAR;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    roen    = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    unique case (1'b1)
      state == ST_CLEAR: begin
        roen    = 1'b1;
        cnt_clr = 1'b1;
        busy_c  = 1'b1;
      end
      state == ST_SETTLE,
      state == ST_DRAIN,
      state == ST_COMPARE: begin
        roen   = 1'b1;
        busy_c = 1'b1;
      end
      state == ST_COUNT: begin
        roen   = 1'b1;
        cnt_en = 1'b1;
        busy_c = 1'b1;
      end
      state == ST_DONE: begin
        done_c = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      chall_q <= '0;
      resp_q  <= '0;
      tie_q   <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.start) begin
        idx     <= '0;
        chall_q <= bus.chall_seed;
        resp_q  <= '0;
        tie_q   <= 1'b0;
      end
      if (state == ST_COMPARE) begin
        for (int i = 0; i < RESP_BITS; i++) begin
          if (idx == SEL_W'(i)) resp_q[i] <= (count0 > count1);
        end
        if (count0 == count1) tie_q <= 1'b1;
        // Select wraps modulo 2**SEL_W by natural overflow.
        if (!last) begin
          idx     <= idx + SEL_W'(1);
          chall_q <= chall_q + SEL_W'(1);
        end
      end
    end
  end

  assign chall0       = chall_q;
  assign chall1       = chall_q;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.response = resp_q;
  assign bus.tie      = tie_q;

endmodule

// File: tb/tb_ro_puf_seq_ctrl.sv
// Directed bench for ro_puf_seq_ctrl with a small config.
// Counter values are stubbed per bit on each cnt_clr.
module tb_ro_puf_seq_ctrl;

  localparam int SEL_W = 8;
  localparam int CNT_W = 16;
  localparam int RB    = 4;
  localparam int ST    = 2;
  localparam int WN    = 8;
  localparam int LAT   = 57;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CNT_W-1:0] count0 = '0;
  logic [CNT_W-1:0] count1 = '0;
  logic             roen;
  logic             cnt_clr;
  logic             cnt_en;
  logic [SEL_W-1:0] chall0;
  logic [SEL_W-1:0] chall1;

  int checks   = 0;
  int failures = 0;

  logic [CNT_W-1:0] tab0 [RB];
  logic [CNT_W-1:0] tab1 [RB];

  int          r_done_cyc;
  logic        r_busy1;
  logic [7:0]  r_chall [RB];
  int          r_en [RB];
  logic [3:0]  r_resp;
  logic        r_tie;

  ro_puf_seq_ctrl_if #(.SEL_W(SEL_W), .RESP_BITS(RB)) bus ();

  ro_puf_seq_ctrl #(
    .SEL_W    (SEL_W),
    .CNT_W    (CNT_W),
    .RESP_BITS(RB),
    .SETTLE   (ST),
    .WINDOW   (WN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .count0 (count0),
    .count1 (count1),
    .roen   (roen),
    .cnt_clr(cnt_clr),
    .cnt_en (cnt_en),
    .chall0 (chall0),
    .chall1 (chall1)
  );

  always #5 clk = ~clk;

  logic       prev_roen = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] prev_ch   = '0;

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (cnt_clr && cnt_en) begin
        failures++;
        $display("FAIL clr_en_overlap got clr=%0b en=%0b need not both",
                 cnt_clr, cnt_en);
      end
      if (cnt_en) begin
        checks++;
        if (roen !== 1'b1) begin
          failures++;
          $display("FAIL roen_with_en got roen=%0b need 1", roen);
        end
      end
      checks++;
      if (chall0 !== chall1) begin
        failures++;
        $display("FAIL chall_match got %h/%h need equal", chall0, chall1);
      end
      if (roen && prev_roen && !cnt_clr) begin
        checks++;
        if (chall0 !== prev_ch) begin
          failures++;
          $display("FAIL chall_stable got %h need %h", chall0, prev_ch);
        end
      end
      if (bus.done) begin
        checks++;
        if (prev_done) begin
          failures++;
          $display("FAIL done_width got 2+ cycles need 1");
        end
      end
    end
    prev_roen = roen;
    prev_ch   = chall0;
    prev_done = bus.done;
  end

  task automatic run_seq(input logic [7:0] seed, input bit mid_start);
    int bi;
    bit pulsed;
    bi         = 0;
    pulsed     = 1'b0;
    r_done_cyc = -1;
    r_busy1    = 1'b0;
    r_resp     = '0;
    r_tie      = 1'b0;
    for (int i = 0; i < RB; i++) begin
      r_en[i]    = 0;
      r_chall[i] = '0;
    end
    @(negedge clk);
    bus.chall_seed = seed;
    bus.start      = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (n == 1) r_busy1 = bus.busy;
      if (cnt_clr) begin
        if (bi < RB) begin
          r_chall[bi] = chall0;
          count0      = tab0[bi];
          count1      = tab1[bi];
        end
        bi++;
      end
      if (cnt_en && bi > 0 && bi <= RB) r_en[bi-1]++;
      if (mid_start && !pulsed && cnt_en && bi == 3) begin
        bus.start = 1'b1;
        pulsed    = 1'b1;
      end
      if (bus.done) begin
        r_done_cyc = n;
        r_resp     = bus.response;
        r_tie      = bus.tie;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [25:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      outs = {roen, cnt_clr, cnt_en, bus.busy, bus.done, bus.tie,
              bus.response, chall0, chall1};
      checks++;
      if (outs !== '0) begin
        failures++;
        $display("FAIL idle_outputs cyc=%0d got %h need 0", n, outs);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    for (int i = 0; i < RB; i++) begin
      tab0[i] = 16'd100;
      tab1[i] = 16'd50;
    end
    run_seq(8'h10, 1'b0);
    checks++;
    if (r_done_cyc !== LAT) begin
      failures++;
      $display("FAIL basic_latency got %0d need %0d", r_done_cyc, LAT);
    end
    checks++;
    if (r_busy1 !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got %0b need 1", r_busy1);
    end
    checks++;
    if (r_resp !== 4'b1111) begin
      failures++;
      $display("FAIL basic_resp got %b need 1111", r_resp);
    end
    checks++;
    if (r_tie !== 1'b0) begin
      failures++;
      $display("FAIL basic_tie got %0b need 0", r_tie);
    end
    for (int i = 0; i < RB; i++) begin
      exp = 8'h10 + 8'(i);
      checks++;
      if (r_chall[i] !== exp) begin
        failures++;
        $display("FAIL basic_chall%0d got %h need %h", i, r_chall[i], exp);
      end
      checks++;
      if (r_en[i] !== WN) begin
        failures++;
        $display("FAIL basic_en%0d got %0d need %0d", i, r_en[i], WN);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.response !== 4'b1111) begin
      failures++;
      $display("FAIL basic_after got done=%0b busy=%0b resp=%b need 0 0 1111",
               bus.done, bus.busy, bus.response);
    end
  endtask

  task automatic check_wrap(input string tag);
    logic [7:0] exp_ch [RB];
    exp_ch[0] = 8'hFE;
    exp_ch[1] = 8'hFF;
    exp_ch[2] = 8'h00;
    exp_ch[3] = 8'h01;
    checks++;
    if (r_done_cyc !== LAT) begin
      failures++;
      $display("FAIL %s_latency got %0d need %0d", tag, r_done_cyc, LAT);
    end
    checks++;
    if (r_resp !== 4'b1001) begin
      failures++;
      $display("FAIL %s_resp got %b need 1001", tag, r_resp);
    end
    checks++;
    if (r_tie !== 1'b1) begin
      failures++;
      $display("FAIL %s_tie got %0b need 1", tag, r_tie);
    end
    for (int i = 0; i < RB; i++) begin
      checks++;
      if (r_chall[i] !== exp_ch[i]) begin
        failures++;
        $display("FAIL %s_chall%0d got %h need %h", tag, i, r_chall[i], exp_ch[i]);
      end
    end
  endtask

  task automatic test_wrap();
    tab0[0] = 16'd60; tab1[0] = 16'd40;
    tab0[1] = 16'd40; tab1[1] = 16'd60;
    tab0[2] = 16'd50; tab1[2] = 16'd50;
    tab0[3] = 16'd70; tab1[3] = 16'd10;
    run_seq(8'hFE, 1'b0);
    check_wrap("wrap");
  endtask

  task automatic test_back_to_back();
    run_seq(8'hFE, 1'b1);
    check_wrap("midstart");
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midstart_queued got busy=%0b need 0", bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    int  bi;
    bit  hit;
    bit  seen_done;
    logic [25:0] outs;
    for (int i = 0; i < RB; i++) begin
      tab0[i] = 16'd100;
      tab1[i] = 16'd50;
    end
    bi  = 0;
    hit = 1'b0;
    @(negedge clk);
    bus.chall_seed = 8'h20;
    bus.start      = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (cnt_clr) begin
        count0 = tab0[0];
        count1 = tab1[0];
        bi++;
      end else if (bi == 2) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit || roen !== 1'b1 || cnt_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_reach_settle got hit=%0b roen=%0b en=%0b need 1 1 0",
               hit, roen, cnt_en);
    end
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    outs = {roen, cnt_clr, cnt_en, bus.busy, bus.done, bus.tie,
            bus.response, chall0, chall1};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL rst_outputs got %h need 0", outs);
    end
    seen_done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_done got activity=%0b need 0", seen_done);
    end
    run_seq(8'h20, 1'b0);
    checks++;
    if (r_done_cyc !== LAT) begin
      failures++;
      $display("FAIL rerun_latency got %0d need %0d", r_done_cyc, LAT);
    end
    checks++;
    if (r_resp !== 4'b1111 || r_chall[0] !== 8'h20) begin
      failures++;
      $display("FAIL rerun_result got resp=%b ch0=%h need 1111 20",
               r_resp, r_chall[0]);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.chall_seed = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_puf_seq_ctrl.md
Name: ro_puf_seq_ctrl

Overview:
Sequencer for the dual-bank ring-oscillator PUF datapath: 2x256 ROs, two 256:1 muxes and two edge counters.
- On a start request it generates RESP_BITS comparisons, one per response bit.
- For each bit it drives the challenge selects, enables the ROs, waits a settle period, gates both counters for a fixed window, then compares the two counts.
- It replaces ad-hoc counter control in the PUF wrapper and is the single owner of roen, counter clear/enable and challenge selects.

Parameters:
SEL_W, 8, challenge select width (log2 of RO count per bank)
CNT_W, 16, width of count0/count1 from the edge counters
RESP_BITS, 8, response bits produced per request (1..2**SEL_W)
SETTLE, 16, cycles with ROs enabled before counting (>=1)
WINDOW, 1024, cycles counters are enabled per comparison (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
chall_seed  in  SEL_W  base challenge, captured on accepted start
count0  in  CNT_W  bank-0 counter value
count1  in  CNT_W  bank-1 counter value
roen  out  1  RO enable, both banks
cnt_clr  out  1  synchronous clear to both counters
cnt_en  out  1  count gate, ANDed with mux outputs
chall0  out  SEL_W  bank-0 mux select
chall1  out  SEL_W  bank-1 mux select
busy  out  1  high from the cycle after accept until DONE exits
done  out  1  1-cycle pulse, response valid
response  out  RESP_BITS  response word, bit i from comparison i
tie  out  1  any comparison had count0==count1; valid with done

Behaviour:
- Reset (rst=1 at edge): state=IDLE, roen=cnt_clr=cnt_en=busy=done=tie=0, chall0=chall1=0, response=0, bit index=0. Reset mid-run aborts immediately; no done pulse.
- IDLE: start=1 captures chall_seed, clears index/tie/response, goes to CLEAR. start while busy is ignored, not queued.
- CLEAR (1 cycle): cnt_clr=1, roen=1, chall0=chall1=(seed+index) mod 2**SEL_W. Wrap-around is required: seed 0xFE, index 3 -> 0x01.
- SETTLE (SETTLE cycles): roen=1, cnt_en=0.
- COUNT (WINDOW cycles): roen=1, cnt_en=1.
- DRAIN (2 cycles): cnt_en=0, roen=1. Covers the counter register latency.
- COMPARE (1 cycle), unsigned compare:
  - response[index] = (count0 > count1).
  - Equal -> bit=0 and tie set (sticky for the request).
- Next step: if index==RESP_BITS-1 -> DONE, else index+1 -> CLEAR.
- DONE (1 cycle): done=1, roen=0, busy=0. Next state is IDLE. start in DONE is ignored.
- chall0/chall1 are held constant from CLEAR through COMPARE of each bit.
- Outside CLEAR..COMPARE, roen=0 and cnt_en=0. cnt_en never asserts in the same cycle as cnt_clr.
- Latency, start accepted at edge k:
  - busy=1 from k+1.
  - Each bit takes SETTLE+WINDOW+4 cycles.
  - done is high in cycle k+1+RESP_BITS*(SETTLE+WINDOW+4).
- response and tie hold their values until the next accepted start or rst.
- Outputs are registered, from the state/timer only; there is no combinational path from start.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, SETTLE, COUNT, DRAIN, COMPARE, DONE) and DRAIN_CYCLES=2 constant. The package also holds the default SEL_W/CNT_W values used by the PUF mux and counter.
- One sub-module, ro_puf_phase_timer: loadable down-counter, width clog2(max(SETTLE,WINDOW)+1), with a load value and an expire pulse. The FSM reloads it on each phase entry.

Test Plan:
- Reset then idle, with SETTLE=2, WINDOW=8, RESP_BITS=4. Hold start=0 for 20 cycles -> all outputs stay 0.
- Start with seed=0x10; stub count0=100, count1=50 -> chall steps 0x10,0x11,0x12,0x13; done exactly 57 cycles after accept; response=4'b1111, tie=0; cnt_en high exactly 8 cycles per bit.
- Seed=0xFE; counts alternate (60,40),(40,60),(50,50),(70,10) per bit -> chall steps 0xFE,0xFF,0x00,0x01; response=4'b1001; tie=1.
- Start pulsed again mid-run (bit 2, COUNT phase) -> ignored; run completes at the same cycle with the same response.
- rst asserted during SETTLE of bit 1 -> next cycle all outputs 0, no done pulse. A following start runs a full 57-cycle sequence.
- Protocol checker over the full run:
  - cnt_clr and cnt_en never high together.
  - roen high whenever cnt_en is high.
  - chall0/chall1 stable from CLEAR through COMPARE.
  - done exactly 1 cycle wide.
